bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that processes one bit pair per clock, LSB first, through a single instance of the team's 1-bit `full_adder` cell plus a registered carry. It sits directly around the full-adder stage. It latches both operands, feeds the cell one bit per cycle, captures the cell's `sum`/`cout` into a result shift register and carry flop, and presents a registered result with flags under a start/done handshake. It is the low-area arithmetic path of the ALU.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal values are ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `opA`  in  WIDTH  operand A, sampled on the accepting edge.
- `opB`  in  WIDTH  operand B, sampled on the accepting edge.
- `sub`  in  1  1 = A−B, 0 = A+B. Sampled on the accepting edge. Present only with `SERIAL_SUB_EN`.
- `ready`  out  1  high in IDLE and DONE.
- `busy`  out  1  high in RUN.
- `done`  out  1  registered one-cycle pulse marking result valid.
- `result`  out  WIDTH  registered sum/difference; holds until the next completion.
- `cout`  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. `ready` = (IDLE|DONE); `busy` = RUN.
- Accept (`start`&`ready`):
  - load `a_sh`←opA and `b_sh`←(sub ? ~opB : opB);
  - `carry`←sub;
  - bit counter←0;
  - go to RUN.
- RUN, each edge:
  - the full_adder is fed `a_sh[0]`, `b_sh[0]` and `carry`;
  - `a_sh` and `b_sh` shift right;
  - the sum bit enters `r_sh[WIDTH-1]` as `r_sh` shifts right;
  - `carry`←cell cout;
  - counter increments.
- On the edge where counter==WIDTH-1:
  - `result`←final `r_sh` including this bit;
  - `cout`←cell cout;
  - `ovf`←`carry` (carry into MSB) XOR cell cout;
  - `done`←1;
  - go to DONE.
- DONE: lasts one cycle. Next edge goes to IDLE with `done`←0, unless `start` is high, in which case the request is accepted and the next state is RUN.
- `start` while RUN is ignored. Operands are not resampled, and the in-flight operation completes with the original operands.
- Counter width is clog2(WIDTH). Counter wrap never occurs because RUN exits at WIDTH-1.
- `result`/`cout`/`ovf` change only on a completion edge or on reset. They are never visibly partial.

## Timing
- Reset (`rst`=1 at an edge), all other inputs ignored:
  - state = IDLE;
  - `result`=0, `cout`=0, `ovf`=0, `done`=0, `busy`=0, `ready`=1;
  - internal shift registers, carry and counter cleared.
- Reset mid-RUN aborts the operation: no `done` pulse, and outputs are forced to their reset values.
- Latency:
  - accepting edge E0;
  - `busy`=1 from after E0 through E_WIDTH;
  - `done`=1 for exactly the cycle following E_WIDTH.
- Throughput: one operation per WIDTH+1 cycles when `start` is held or re-asserted in DONE.
- Simultaneous `rst` and `start`: reset wins.

## Configuration
- `SERIAL_SUB_EN` defined:
  - the `sub` port exists;
  - subtraction inverts B at load and seeds `carry`=1.
- `SERIAL_SUB_EN` undefined:
  - the `sub` port is absent;
  - `b_sh` loads opB unmodified and `carry` seeds 0;
  - all other behaviour and latency are identical.

## Test plan
- Reset, then hold idle: `ready`=1, `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0.
  - WIDTH=8, opA=8'h3C, opB=8'h0F, add, `start` for one cycle:
  - `done` pulses in the cycle after the 8th edge following acceptance;
  - `result`=8'h4B, `cout`=0, `ovf`=0.
- Add boundary cases:
  - 8'hFF+8'h01 gives `result`=8'h00, `cout`=1, `ovf`=0;
  - 8'h7F+8'h01 gives `result`=8'h80, `cout`=0, `ovf`=1.
- With `SERIAL_SUB_EN`:
  - 8'h05−8'h07 gives `result`=8'hFE, `cout`=0, `ovf`=0;
  - 8'h80−8'h01 gives `result`=8'h7F, `cout`=1, `ovf`=1.
- Start 8'h10+8'h20, then pulse `start` with 8'hFF/8'hFF at RUN cycle 3:
  - the second request is ignored;
  - exactly one `done` with `result`=8'h30.
- Assert `rst` at RUN cycle 4:
  - the next cycle shows `ready`=1, `busy`=0, `result`=0, and no `done` ever appears;
  - a following 8'h01+8'h01 completes with 8'h02.
- Hold `start` high through DONE with new operands 8'h0A/8'h05:
  - accepted in the DONE cycle, `busy`=1 on the next cycle;
  - second `done` arrives 9 cycles after the first, with `result`=8'h0F.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for bit_serial_adder.
// The sub request line exists only when SERIAL_SUB_EN is defined.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    output start, opA, opB,
    input  ready, busy, done, result, cout, ovf
  );

  modport slave (
`ifdef SERIAL_SUB_EN
    input  sub,
`endif
    input  start, opA, opB,
    output ready, busy, done, result, cout, ovf
  );
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder around a single 1-bit full_adder cell.
// Define SERIAL_SUB_EN to add the sub request (A-B via inverted B and carry-in 1).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  bit_serial_adder_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] result_q;
  logic             carry, cout_q, ovf_q, done_q;
  logic             fa_sum, fa_cout;
  logic             ready, accept, last, sub_in;

`ifdef SERIAL_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = bus.start && ready;
  assign last   = (cnt == LAST);

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_sh  <= bus.opA;
        b_sh  <= sub_in ? ~bus.opB : bus.opB;
        r_sh  <= '0;
        carry <= sub_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        r_sh  <= {fa_sum, r_sh[WIDTH-1:1]};
        carry <= fa_cout;
        cnt   <= cnt + 1'b1;
        // carry still holds the carry into the MSB on the final edge
        if (last) begin
          result_q <= {fa_sum, r_sh[WIDTH-1:1]};
          cout_q   <= fa_cout;
          ovf_q    <= carry ^ fa_cout;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized and directed bench for bit_serial_adder against an arithmetic model.
module tb_bit_serial_adder;
  localparam int unsigned W = 8;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start = st;
    bus.opA   = a;
    bus.opB   = b;
`ifdef SERIAL_SUB_EN
    bus.sub   = s;
`else
    if (s) $display("note: sub requested without SERIAL_SUB_EN");
`endif
  endtask

  function automatic int to_signed(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Plain integer arithmetic: wrap the true result, carry = no unsigned overflow/borrow rule.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o);
    int ua, ub, sr, ur;
    ua = int'(a);
    ub = int'(b);
    ur = s ? ua - ub : ua + ub;
    r  = W'(ur);
    c  = s ? (ua >= ub) : (ur >= (1 << W));
    sr = s ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
    o  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endfunction

  // Launch one request and wait for done; lat counts edges after the accepting edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic o,
                        output int lat, output bit timeout);
    drive(1'b1, a, b, s);
    tick();
    bus.start = 1'b0;
    timeout = 1'b1;
    lat = 0;
    r = '0; c = 1'b0; o = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i; r = bus.result; c = bus.cout; o = bus.ovf; timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle: rdy=%b busy=%b done=%b res=%h cout=%b ovf=%b, want 1 0 0 00 0 0",
                 bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.ovf);
      end
    end
    rst = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_beats_start: busy=%b ready=%b, want 0 1", bus.busy, bus.ready);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_start_late: busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_add_directed();
    logic [W-1:0] va [3] = '{8'h3C, 8'hFF, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h0F, 8'h01, 8'h01};
    logic [W-1:0] er [3] = '{8'h4B, 8'h00, 8'h80};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] r; logic c, o; int lat; bit to;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], 1'b0, r, c, o, lat, to);
      total++;
      if (to || lat != W || {r, c, o} !== {er[k], ec[k], eo[k]}) begin
        bad++;
        $display("FAIL add_directed[%0d]: timeout=%0b lat=%0d res=%h cout=%b ovf=%b, want lat=%0d res=%h cout=%b ovf=%b",
                 k, to, lat, r, c, o, W, er[k], ec[k], eo[k]);
      end
      tick();
    end
  endtask

  task automatic test_sub_directed();
    logic [W-1:0] va [2] = '{8'h05, 8'h80};
    logic [W-1:0] vb [2] = '{8'h07, 8'h01};
    logic [W-1:0] er [2] = '{8'hFE, 8'h7F};
    logic         ec [2] = '{1'b0, 1'b1};
    logic         eo [2] = '{1'b0, 1'b1};
    logic [W-1:0] r; logic c, o; int lat; bit to;
    for (int k = 0; k < 2; k++) begin
      run_op(va[k], vb[k], 1'b1, r, c, o, lat, to);
      total++;
      if (to || {r, c, o} !== {er[k], ec[k], eo[k]}) begin
        bad++;
        $display("FAIL sub_directed[%0d]: timeout=%0b res=%h cout=%b ovf=%b, want res=%h cout=%b ovf=%b",
                 k, to, r, c, o, er[k], ec[k], eo[k]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, mr; logic s, c, o, mc, mo; int lat; bit to;
    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      model(a, b, s, mr, mc, mo);
      run_op(a, b, s, r, c, o, lat, to);
      total++;
      if (to || lat != W || {r, c, o} !== {mr, mc, mo}) begin
        bad++;
        $display("FAIL random[%0d] %h %s %h: timeout=%0b lat=%0d res=%h cout=%b ovf=%b, want res=%h cout=%b ovf=%b",
                 k, a, s ? "-" : "+", b, to, lat, r, c, o, mr, mc, mo);
      end
      if (k % 3 == 0) tick();
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    logic [W-1:0] r = '0;
    drive(1'b1, 8'h10, 8'h20, 1'b0);
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept: busy=%b, want 1", bus.busy);
    end
    tick(); tick(); tick();
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        dones++;
        r = bus.result;
      end
    end
    total++;
    if (dones != 1 || r !== 8'h30) begin
      bad++;
      $display("FAIL start_ignored: dones=%0d res=%h, want 1 and 30", dones, r);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    logic [W-1:0] r; logic c, o; int lat; bit to;
    drive(1'b1, 8'h55, 8'h11, 1'b0);
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 8'h00 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: ready=%b busy=%b done=%b res=%h, want 1 0 0 00",
               bus.ready, bus.busy, bus.done, bus.result);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_no_done: dones=%0d, want 0", dones);
    end
    run_op(8'h01, 8'h01, 1'b0, r, c, o, lat, to);
    total++;
    if (to || r !== 8'h02) begin
      bad++;
      $display("FAIL after_reset_op: timeout=%0b res=%h, want 02", to, r);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    bit got1 = 1'b0, got2 = 1'b0;
    logic [W-1:0] r1 = '0, r2 = '0;
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    tick();
    drive(1'b1, 8'h0A, 8'h05, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.done === 1'b1) begin got1 = 1'b1; r1 = bus.result; break; end
    end
    total++;
    if (!got1 || r1 !== 8'h33) begin
      bad++;
      $display("FAIL b2b_first: seen=%0b res=%h, want 1 and 33", got1, r1);
    end
    tick();
    bus.start = 1'b0;
    gap = 1;
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept_in_done: busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      gap++;
      if (bus.done === 1'b1) begin got2 = 1'b1; r2 = bus.result; break; end
    end
    total++;
    if (!got2 || gap != W + 1 || r2 !== 8'h0F) begin
      bad++;
      $display("FAIL b2b_second: seen=%0b gap=%0d res=%h, want 1 gap=%0d res=0F", got2, gap, r2, W + 1);
    end
    tick();
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_add_directed();
    if (SUB_EN) test_sub_directed();
    test_random();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
